regfile_rv32: RTL and testbench



---
 rtl/regfile_rv32_if.sv | 50 +++++
 rtl/regfile_rv32.sv | 112 +++++++++++
 tb/tb_regfile_rv32.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_rv32_if.sv
// ---------------------------------------------------------------------------
// regfile_rv32_if
//
// Bundles every non-clock/non-reset signal of the RV32I register file.
//
//   Writeback : iDregADDR, iDregDATA     (address 0 means "no write")
//   Read      : iRs1ADDR, iRs2ADDR, iRdEN -> oRs1DATA, oRs2DATA, oRdVALID
//   Issue     : iIssueVALID, iIssueRD    (marks a register pending)
//   Hazard    : oRs1BUSY, oRs2BUSY, oHAZARD (combinational)
//
// Modports:
//   master : the pipeline side (writeback + decode); drives the i* signals.
//   slave  : the register file; drives the o* signals.
// ---------------------------------------------------------------------------
interface regfile_rv32_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   iDregADDR;
    logic [XLEN-1:0] iDregDATA;
    logic [AW-1:0]   iRs1ADDR;
    logic [AW-1:0]   iRs2ADDR;
    logic            iRdEN;
    logic [XLEN-1:0] oRs1DATA;
    logic [XLEN-1:0] oRs2DATA;
    logic            oRdVALID;
    logic            iIssueVALID;
    logic [AW-1:0]   iIssueRD;
    logic            oRs1BUSY;
    logic            oRs2BUSY;
    logic            oHAZARD;

    modport master (
        output iDregADDR, iDregDATA,
        output iRs1ADDR, iRs2ADDR, iRdEN,
        output iIssueVALID, iIssueRD,
        input  oRs1DATA, oRs2DATA, oRdVALID,
        input  oRs1BUSY, oRs2BUSY, oHAZARD
    );

    modport slave (
        input  iDregADDR, iDregDATA,
        input  iRs1ADDR, iRs2ADDR, iRdEN,
        input  iIssueVALID, iIssueRD,
        output oRs1DATA, oRs2DATA, oRdVALID,
        output oRs1BUSY, oRs2BUSY, oHAZARD
    );
endinterface

// File: rtl/regfile_rv32.sv
// ---------------------------------------------------------------------------
// regfile_rv32
//
// Architectural register file plus pending-write scoreboard for an RV32I
// pipeline.
//
//   iCLK  : clock, all state updates on the rising edge
//   iRST  : synchronous active-high reset; clears registers, scoreboard and
//           the read outputs
//   bus   : regfile_rv32_if.slave
//           - writeback port commits iDregDATA to iDregADDR (x0 ignored)
//           - two registered read ports with same-cycle writeback bypass
//           - busy flags / hazard computed combinationally from the
//             scoreboard and the current read addresses
// ---------------------------------------------------------------------------
module regfile_rv32 #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic           iCLK,
    input  logic           iRST,
    regfile_rv32_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    // Register array and scoreboard
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Registered read outputs
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic            rd_valid_q, rd_valid_d;

    logic wr_en;
    logic issue_en;
    logic wb_hit1;
    logic wb_hit2;

    assign wr_en    = (bus.iDregADDR != '0);
    assign issue_en = bus.iIssueVALID && (bus.iIssueRD != '0);

    // A writeback to the address being read this cycle: the read takes the
    // incoming data and the busy flag is masked, since the value is here now.
    assign wb_hit1 = wr_en && (bus.iDregADDR == bus.iRs1ADDR);
    assign wb_hit2 = wr_en && (bus.iDregADDR == bus.iRs2ADDR);

    // Per-register next state. Entry 0 is tied off so x0 reads as zero and
    // can never be marked busy.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                assign regs_d[gi] = '0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_xn
                logic wr_sel;
                logic iss_sel;
                assign wr_sel  = wr_en    && (bus.iDregADDR == AW'(gi));
                assign iss_sel = issue_en && (bus.iIssueRD  == AW'(gi));

                assign regs_d[gi] = wr_sel ? bus.iDregDATA : regs_q[gi];
                // Issue beats writeback: a new producer has just been sent
                // down the pipe, so the register is still pending.
                assign busy_d[gi] = iss_sel ? 1'b1 :
                                    wr_sel  ? 1'b0 : busy_q[gi];
            end
        end
    endgenerate

    // Read ports: capture on iRdEN, otherwise hold.
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_valid_d = bus.iRdEN;
        if (bus.iRdEN) begin
            rs1_data_d = wb_hit1 ? bus.iDregDATA : regs_q[bus.iRs1ADDR];
            rs2_data_d = wb_hit2 ? bus.iDregDATA : regs_q[bus.iRs2ADDR];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.oRs1DATA = rs1_data_q;
    assign bus.oRs2DATA = rs2_data_q;
    assign bus.oRdVALID = rd_valid_q;

    assign bus.oRs1BUSY = busy_q[bus.iRs1ADDR] & ~wb_hit1;
    assign bus.oRs2BUSY = busy_q[bus.iRs2ADDR] & ~wb_hit2;
    assign bus.oHAZARD  = bus.iRdEN & (bus.oRs1BUSY | bus.oRs2BUSY);

endmodule

// File: tb/tb_regfile_rv32.sv
module tb_regfile_rv32;
    logic clk;
    logic rst;

    regfile_rv32_if #(.XLEN(32), .NREG(32)) bus ();

    regfile_rv32 #(.XLEN(32), .NREG(32)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    logic [31:0] model_regs [32];
    logic [31:0] last_r1;
    logic [31:0] last_r2;
    logic        exp_valid;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: predict read results from the reference register contents,
    // advance the model, then compare the DUT just after the edge.
    task automatic tick();
        rd_exp_t e;
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = '0;
            exp_q.delete();
            last_r1   = '0;
            last_r2   = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = bus.iRdEN;
            if (bus.iRdEN) begin
                e.r1 = (bus.iDregADDR != 0 && bus.iDregADDR == bus.iRs1ADDR)
                       ? bus.iDregDATA : model_regs[bus.iRs1ADDR];
                e.r2 = (bus.iDregADDR != 0 && bus.iDregADDR == bus.iRs2ADDR)
                       ? bus.iDregDATA : model_regs[bus.iRs2ADDR];
                exp_q.push_back(e);
            end
            if (bus.iDregADDR != 0) model_regs[bus.iDregADDR] = bus.iDregDATA;
        end
        @(posedge clk);
        #1;
        chk("rd_valid", {31'b0, bus.oRdVALID}, {31'b0, exp_valid});
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                last_r1 = e.r1;
                last_r2 = e.r2;
            end
        end
        chk("rs1_data", bus.oRs1DATA, last_r1);
        chk("rs2_data", bus.oRs2DATA, last_r2);
        $display("cycle t=%0t rst=%0b valid=%0b rs1=%08h rs2=%08h", $time, rst,
                 bus.oRdVALID, bus.oRs1DATA, bus.oRs2DATA);
    endtask

    task automatic idle_inputs();
        bus.iDregADDR   = '0;
        bus.iDregDATA   = '0;
        bus.iRs1ADDR    = '0;
        bus.iRs2ADDR    = '0;
        bus.iRdEN       = 1'b0;
        bus.iIssueVALID = 1'b0;
        bus.iIssueRD    = '0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_r1   = '0;
        last_r2   = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        idle_inputs();

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("reset_busy1", {31'b0, bus.oRs1BUSY}, 32'd0);
        chk("reset_hazard", {31'b0, bus.oHAZARD}, 32'd0);
        rst = 1'b0;

        // Write x5 then read it back with x0 on port 2
        bus.iDregADDR = 5'd5; bus.iDregDATA = 32'hDEADBEEF;
        tick();
        bus.iDregADDR = 5'd0; bus.iDregDATA = '0;
        bus.iRs1ADDR = 5'd5; bus.iRs2ADDR = 5'd0; bus.iRdEN = 1'b1;
        tick();
        chk("x5_direct", bus.oRs1DATA, 32'hDEADBEEF);
        chk("x0_direct", bus.oRs2DATA, 32'h0);
        bus.iRdEN = 1'b0;
        tick();   // outputs hold, valid drops

        // Write to x0 is discarded; issue to x0 does not set busy
        bus.iDregADDR = 5'd0; bus.iDregDATA = 32'h12345678;
        bus.iIssueVALID = 1'b1; bus.iIssueRD = 5'd0;
        tick();
        bus.iIssueVALID = 1'b0;
        bus.iDregDATA = '0;
        bus.iRs1ADDR = 5'd0; bus.iRs2ADDR = 5'd0; bus.iRdEN = 1'b1;
        #1;
        chk("x0_never_busy", {31'b0, bus.oRs1BUSY}, 32'd0);
        tick();
        chk("x0_reads_zero", bus.oRs1DATA, 32'h0);

        // Same-cycle write and read of x7 (bypass on both ports)
        bus.iDregADDR = 5'd7; bus.iDregDATA = 32'hA5A5A5A5;
        bus.iRs1ADDR = 5'd7; bus.iRs2ADDR = 5'd7; bus.iRdEN = 1'b1;
        tick();
        chk("bypass_rs1", bus.oRs1DATA, 32'hA5A5A5A5);
        chk("bypass_rs2", bus.oRs2DATA, 32'hA5A5A5A5);
        idle_inputs();

        // Issue rd=3, then hazard, then writeback clears it combinationally
        bus.iIssueVALID = 1'b1; bus.iIssueRD = 5'd3;
        tick();
        bus.iIssueVALID = 1'b0;
        bus.iRs1ADDR = 5'd3; bus.iRs2ADDR = 5'd5; bus.iRdEN = 1'b1;
        #1;
        chk("x3_busy", {31'b0, bus.oRs1BUSY}, 32'd1);
        chk("x3_hazard", {31'b0, bus.oHAZARD}, 32'd1);
        chk("x5_not_busy", {31'b0, bus.oRs2BUSY}, 32'd0);
        bus.iRdEN = 1'b0;
        #1;
        chk("hazard_needs_rden", {31'b0, bus.oHAZARD}, 32'd0);
        bus.iRdEN = 1'b1;
        bus.iDregADDR = 5'd3; bus.iDregDATA = 32'h33330003;
        #1;
        chk("x3_busy_masked", {31'b0, bus.oRs1BUSY}, 32'd0);
        chk("x3_hazard_masked", {31'b0, bus.oHAZARD}, 32'd0);
        tick();
        chk("x3_new_data", bus.oRs1DATA, 32'h33330003);
        idle_inputs();
        bus.iRs1ADDR = 5'd3;
        #1;
        chk("x3_cleared", {31'b0, bus.oRs1BUSY}, 32'd0);

        // Simultaneous issue and writeback to x9: set wins
        bus.iIssueVALID = 1'b1; bus.iIssueRD = 5'd9;
        bus.iDregADDR = 5'd9; bus.iDregDATA = 32'h00000099;
        tick();
        idle_inputs();
        bus.iRs2ADDR = 5'd9;
        #1;
        chk("x9_set_wins", {31'b0, bus.oRs2BUSY}, 32'd1);
        bus.iDregADDR = 5'd9; bus.iDregDATA = 32'h00009999;
        tick();
        bus.iDregADDR = 5'd0;
        #1;
        chk("x9_cleared", {31'b0, bus.oRs2BUSY}, 32'd0);
        bus.iRs1ADDR = 5'd9; bus.iRdEN = 1'b1;
        tick();
        chk("x9_data", bus.oRs1DATA, 32'h00009999);
        idle_inputs();

        // Load x1..x31, mark x4 busy, read a sample back
        for (int i = 1; i < 32; i++) begin
            bus.iDregADDR = 5'(i);
            bus.iDregDATA = 32'h01010101 * i ^ 32'hF0000000;
            tick();
        end
        bus.iDregADDR = 5'd0;
        bus.iIssueVALID = 1'b1; bus.iIssueRD = 5'd4;
        bus.iRs1ADDR = 5'd17; bus.iRs2ADDR = 5'd31; bus.iRdEN = 1'b1;
        tick();
        bus.iIssueVALID = 1'b0; bus.iRdEN = 1'b0;
        bus.iRs1ADDR = 5'd4;
        #1;
        chk("x4_busy", {31'b0, bus.oRs1BUSY}, 32'd1);

        // Reset mid-stream for 2 cycles with activity on the inputs
        rst = 1'b1;
        bus.iRdEN = 1'b1; bus.iRs2ADDR = 5'd31;
        bus.iDregADDR = 5'd6; bus.iDregDATA = 32'h66666666;
        bus.iIssueVALID = 1'b1; bus.iIssueRD = 5'd8;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_valid", {31'b0, bus.oRdVALID}, 32'd0);
            chk("rst_busy1", {31'b0, bus.oRs1BUSY}, 32'd0);
            chk("rst_hazard", {31'b0, bus.oHAZARD}, 32'd0);
        end
        rst = 1'b0;
        idle_inputs();
        bus.iRs1ADDR = 5'd8;
        #1;
        chk("post_rst_x8_busy", {31'b0, bus.oRs1BUSY}, 32'd0);

        // Everything reads back as zero after reset
        for (int i = 1; i < 32; i++) begin
            bus.iRs1ADDR = 5'(i);
            bus.iRs2ADDR = 5'(32 - i);
            bus.iRdEN = 1'b1;
            tick();
            chk("post_rst_zero", bus.oRs1DATA | bus.oRs2DATA, 32'h0);
        end
        bus.iRdEN = 1'b0;
        tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound in case the clock loop misbehaves
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
